// File: rtl/mj32_pkg.sv
// Shared constants for the iterative RV32M multiply/divide unit:
// funct3 opcodes, FSM state encoding and operand signedness decode.
package mj32_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] MD_MUL    = 3'b000;
  localparam logic [2:0] MD_MULH   = 3'b001;
  localparam logic [2:0] MD_MULHSU = 3'b010;
  localparam logic [2:0] MD_MULHU  = 3'b011;
  localparam logic [2:0] MD_DIV    = 3'b100;
  localparam logic [2:0] MD_DIVU   = 3'b101;
  localparam logic [2:0] MD_REM    = 3'b110;
  localparam logic [2:0] MD_REMU   = 3'b111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Returns {op_a is signed, op_b is signed} for a funct3 code.
  function automatic logic [1:0] op_signs(input logic [2:0] f3);
    case (f3)
      MD_MUL, MD_MULH, MD_DIV, MD_REM: op_signs = 2'b11;
      MD_MULHSU:                       op_signs = 2'b10;
      default:                         op_signs = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per cycle on operand
// magnitudes, sign fix-up at the end, single register_file write on done.
module muldiv_unit
  import mj32_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            C,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            we_out,
  output logic [1:0]      dbg_state
);

  // Handshake: start is taken on any edge where busy=0 and kill=0 (IDLE or
  // DONE); done/we_out pulse high for exactly one cycle per accepted, unkilled op.

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [2:0]        op_q;
  logic [4:0]        rd_q;
  logic              sa_q, sb_q;
  logic              div0_q, ovf_q;
  logic [XLEN-1:0]   mag_a, mag_b;
  // Multiply: running product. Divide: {remainder, dividend/quotient}.
  logic [2*XLEN-1:0] acc;

  logic [1:0]        signs_in;
  logic              sa_in, sb_in, accept;
  logic [XLEN-1:0]   mag_a_in, mag_b_in;
  logic              div0_in, ovf_in;

  always_comb begin
    signs_in = op_signs(funct3);
    sa_in    = signs_in[1] & op_a[XLEN-1];
    sb_in    = signs_in[0] & op_b[XLEN-1];
    mag_a_in = sa_in ? -op_a : op_a;
    mag_b_in = sb_in ? -op_b : op_b;
    div0_in  = (op_b == '0);
    ovf_in   = (funct3 == MD_DIV || funct3 == MD_REM) &&
               (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    accept   = start && !kill;
  end

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_trial, div_diff;
  logic [2*XLEN-1:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a} : '0);
    mul_next = {mul_sum, acc[XLEN-1:1]};
    div_trial = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_trial - {1'b0, mag_b};
    if (!div_diff[XLEN])
      div_next = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      div_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = (sa_q ^ sb_q) ? -acc : acc;
    quo_fix  = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    rem_fix  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    // Special cases were decided at issue; they override the iterated value.
    if (div0_q) begin
      quo_fix = '1;
      rem_fix = sa_q ? -mag_a : mag_a;
    end else if (ovf_q) begin
      quo_fix = {1'b1, {(XLEN-1){1'b0}}};
      rem_fix = '0;
    end
    case (op_q)
      MD_MUL:                      fix_val = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:             fix_val = quo_fix;
      default:                     fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      count  <= '0;
      op_q   <= '0;
      rd_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      div0_q <= 1'b0;
      ovf_q  <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state  <= ST_CALC;
            count  <= '0;
            op_q   <= funct3;
            rd_q   <= rd_in;
            sa_q   <= sa_in;
            sb_q   <= sb_in;
            div0_q <= div0_in;
            ovf_q  <= ovf_in;
            mag_a  <= mag_a_in;
            mag_b  <= mag_b_in;
            acc    <= funct3[2] ? {{XLEN{1'b0}}, mag_a_in} : {{XLEN{1'b0}}, mag_b_in};
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CALC: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            acc   <= op_q[2] ? div_next : mul_next;
            count <= count + 1'b1;
            if (count == LAST) state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (kill) begin
            state <= ST_IDLE;
          end else begin
            result <= fix_val;
            rd_out <= rd_q;
            state  <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state == ST_CALC) || (state == ST_FIX);
  assign done      = (state == ST_DONE);
  assign we_out    = done;
  assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, multi-cycle corner sequences
// and random ops checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        C;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  rd_in;
  logic        kill;
  logic        busy, done, we_out;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  muldiv_unit #(.XLEN(32)) dut (
    .C(C), .rst(rst), .start(start), .funct3(funct3), .op_a(op_a), .op_b(op_b),
    .rd_in(rd_in), .kill(kill), .busy(busy), .done(done), .result(result),
    .rd_out(rd_out), .we_out(we_out), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial C = 1'b0;
  always #5 C = ~C;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb, ub, p;
    logic [63:0] up;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    ia = a;
    ib = b;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Waits for done (sampled at negedge), counting posedges; edges=-1 on timeout.
  task automatic wait_done(input int start_edges, output int edges);
    edges = start_edges;
    for (int i = 0; i < 100; i++) begin
      @(posedge C);
      edges++;
      @(negedge C);
      if (done) return;
    end
    edges = -1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge C);
    funct3 = f; op_a = a; op_b = b; rd_in = rd; start = 1'b1;
    @(posedge C);
    @(negedge C);
    start = 1'b0;
  endtask

  // Full op from idle: latency, result, rd_out, we_out, one-cycle done.
  task automatic run_op(input string nm, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    int edges;
    logic [31:0] e;
    exp_q.push_back(model(f, a, b));
    issue(f, a, b, rd);
    check({nm, "_busy"}, {31'b0, busy}, 32'd1);
    wait_done(1, edges);
    e = exp_q.pop_front();
    check({nm, "_latency"}, edges, 32'd34);
    check({nm, "_result"}, result, e);
    check({nm, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
    check({nm, "_we"}, {31'b0, we_out}, 32'd1);
    @(posedge C);
    @(negedge C);
    check({nm, "_done_1cyc"}, {30'b0, we_out, done}, 32'd0);
  endtask

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] rand_opnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs[14];
    int edges, dones;
    logic [31:0] e, a, b;
    logic [2:0] f;
    logic [4:0] rd;

    vecs[0]  = '{"mul_7xm3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{"mulh_min_m1",   3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[2]  = '{"mulhsu_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[3]  = '{"mulhu_min_m1",  3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    vecs[4]  = '{"div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    vecs[5]  = '{"rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    vecs[6]  = '{"divu_big_16",   3'd5, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF};
    vecs[7]  = '{"div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[8]  = '{"remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5};
    vecs[9]  = '{"div_ovf",       3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[10] = '{"rem_ovf",       3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{"rem_m5_0",      3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    vecs[12] = '{"divu_5_0",      3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{"mulhu_m1_m1",   3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};

    rst = 1'b1; start = 1'b0; kill = 1'b0;
    funct3 = '0; op_a = '0; op_b = '0; rd_in = '0;
    repeat (2) @(posedge C);
    @(negedge C);
    check("reset_outs", {busy, done, we_out, rd_out, dbg_state}, 32'd0);
    check("reset_result", result, 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 14; i++) begin
      rd = 5'(i + 1);
      issue(vecs[i].f, vecs[i].a, vecs[i].b, rd);
      wait_done(1, edges);
      check({vecs[i].name, "_latency"}, edges, 32'd34);
      check({vecs[i].name, "_result"}, result, vecs[i].exp);
      check({vecs[i].name, "_rd"}, {27'b0, rd_out}, {27'b0, rd});
      check({vecs[i].name, "_we"}, {31'b0, we_out}, 32'd1);
      @(posedge C);
      @(negedge C);
      check({vecs[i].name, "_done_1cyc"}, {31'b0, done}, 32'd0);
    end

    // rd_in = 0 still writes.
    run_op("rd0_mul", 3'd0, 32'd3, 32'd4, 5'd0);

    // Kill partway through a DIV: no done, idle next cycle, result held.
    issue(3'd4, 32'd100, 32'd7, 5'd5);
    repeat (8) @(posedge C);
    @(negedge C);
    kill = 1'b1;
    @(posedge C);
    @(negedge C);
    kill = 1'b0;
    check("kill_busy", {31'b0, busy}, 32'd0);
    check("kill_done", {31'b0, done}, 32'd0);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge C);
      if (done || we_out) dones++;
    end
    check("kill_no_write", dones, 32'd0);
    check("kill_result_held", result, 32'd12);

    // kill and start together in IDLE: start dropped.
    @(negedge C);
    funct3 = 3'd0; op_a = 32'd2; op_b = 32'd2; rd_in = 5'd3;
    start = 1'b1; kill = 1'b1;
    @(posedge C);
    @(negedge C);
    start = 1'b0; kill = 1'b0;
    check("kill_start_drop", {31'b0, busy}, 32'd0);

    // Async reset mid-CALC clears outputs without a clock edge.
    issue(3'd0, 32'd9, 32'd9, 5'd17);
    repeat (5) @(posedge C);
    @(negedge C);
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl", {busy, done, we_out, rd_out, dbg_state}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge C);
    rst = 1'b0;

    // Back-to-back with start held into the DONE cycle; a start pulse while
    // busy must be ignored.
    issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd4);
    wait_done(1, edges);
    check("b2b_first_latency", edges, 32'd34);
    check("b2b_first_result", result, 32'hFFFF_FFEB);
    funct3 = 3'd4; op_a = 32'hFFFF_FFF9; op_b = 32'd2; rd_in = 5'd9; start = 1'b1;
    @(posedge C);
    @(negedge C);
    start = 1'b0;
    check("b2b_no_gap", {31'b0, busy}, 32'd1);
    repeat (4) @(posedge C);
    @(negedge C);
    funct3 = 3'd0; op_a = 32'd1; op_b = 32'd1; rd_in = 5'd1; start = 1'b1;
    @(posedge C);
    @(negedge C);
    start = 1'b0;
    wait_done(6, edges);
    check("b2b_second_latency", edges, 32'd34);
    check("b2b_second_result", result, 32'hFFFF_FFFD);
    check("b2b_second_rd", {27'b0, rd_out}, 32'd9);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge C);
      if (done) dones++;
    end
    check("busy_start_ignored", dones, 32'd0);

    // Random ops against the reference model.
    for (int i = 0; i < 200; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = rand_opnd();
      b  = rand_opnd();
      rd = 5'($urandom_range(0, 31));
      exp_q.push_back(model(f, a, b));
      issue(f, a, b, rd);
      wait_done(1, edges);
      e = exp_q.pop_front();
      check("rand_latency", edges, 32'd34);
      if (result !== e) begin
        $display("FAIL rand_result f3=%0d a=%h b=%h: got %h expected %h", f, a, b, result, e);
        n_fail++;
      end
      n_cmp++;
      check("rand_rd", {27'b0, rd_out}, {27'b0, rd});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
